// File: rtl/ps2_scan_receiver_if.sv
// rtl/ps2_scan_receiver_if.sv - PS/2 line and key-event signal bundle
interface ps2_scan_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] data_out;
    logic       ready;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output data_out,
        output ready,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  data_out,
        input  ready,
        input  frame_err
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 frame receiver folding E0/F0 prefixes into key events
module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_scan_receiver_if.master  bus
);
    localparam int FW   = $clog2(FILTER_LEN) + 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          ext, ext_n, brk, brk_n;
    logic [9:0]    data_q, data_n;
    logic          ready_q, ready_n, err_q, err_n;

    // Sync and filter reset to the idle-high level so release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= bus.ps2_clk;
            clk_s2     <= clk_s1;
            data_s1    <= bus.ps2_data;
            data_s2    <= data_s1;
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par_bit <= par_bit_n;
            to_cnt  <= to_cnt_n;
            ext     <= ext_n;
            brk     <= brk_n;
            data_q  <= data_n;
            ready_q <= ready_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_bit_n = par_bit;
        ext_n     = ext;
        brk_n     = brk;
        data_n    = data_q;
        ready_n   = 1'b0;
        err_n     = 1'b0;
        to_cnt_n  = (state == IDLE || fall) ? '0 : to_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (fall && !data_s2) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_n   = {data_s2, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_bit_n = data_s2;
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (data_s2 && (^shift ^ par_bit)) begin
                        if (shift == 8'hE0) begin
                            ext_n = 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk_n = 1'b1;
                        end else begin
                            data_n  = {ext, brk, shift};
                            ready_n = 1'b1;
                            ext_n   = 1'b0;
                            brk_n   = 1'b0;
                        end
                    end else begin
                        err_n = 1'b1;
                        ext_n = 1'b0;
                        brk_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A falling edge in the same cycle keeps the frame alive.
        if (state != IDLE && !fall && to_cnt == TO_MAX) begin
            state_n = IDLE;
            err_n   = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.ready     = ready_q;
    assign bus.frame_err = err_q;
endmodule
